// File: rtl/pkt_merger_pkg.sv
// pkt_merger_pkg
//   Shared packet definitions used on both sides of the packet router, so the
//   router's egress array plugs straight into the merger's inputs.
//   Contents:
//     PACKET_BITS   packet width (key at KEY_LSB, payload above the key)
//     NUM_CHANNELS  number of router egress channels
//     KEY_LSB       bit position of the 32-bit key inside a packet
//     KEY_BITS      key width
//     CHAN_BITS     width of a channel index
//     packet_t      one packet
//     chan_idx_t    one channel index
package pkt_merger_pkg;

  localparam int PACKET_BITS  = 72;
  localparam int NUM_CHANNELS = 8;
  localparam int KEY_LSB      = 8;
  localparam int KEY_BITS     = 32;
  localparam int CHAN_BITS    = $clog2(NUM_CHANNELS);

  typedef logic [PACKET_BITS-1:0] packet_t;
  typedef logic [CHAN_BITS-1:0]   chan_idx_t;

endpackage

// File: rtl/pkt_merger_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at the channel
//   after ptr and wraps around, so the channel at ptr itself is searched last.
//   The pointer register is owned by the instantiating block.
//   Ports:
//     req        in   one request bit per channel
//     advance    in   grant may be issued this cycle (gates the one-hot output)
//     ptr        in   channel granted most recently
//     grant      out  one-hot grant, all zero when !advance or no request
//     grant_idx  out  encoded index of the winning channel (ptr when no request)
module rr_arbiter
  import pkt_merger_pkg::*;
#(
  parameter  int NUM_CHANNELS = pkt_merger_pkg::NUM_CHANNELS,
  localparam int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic                    advance,
  input  logic [CHAN_BITS-1:0]    ptr,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [CHAN_BITS-1:0]    grant_idx
);

  logic [CHAN_BITS-1:0] cand;
  logic                 found;

  // NUM_CHANNELS is a power of two, so truncating ptr+i to CHAN_BITS gives the
  // wrap-around for free; i == NUM_CHANNELS lands back on ptr itself.
  always_comb begin
    grant_idx = ptr;
    found     = 1'b0;
    cand      = ptr;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = ptr + CHAN_BITS'(i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
    grant = '0;
    if (advance && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/pkt_merger.sv
// pkt_merger
//   Merges the router's per-channel egress streams into one output stream.
//   A round-robin arbiter picks one valid channel per cycle and the chosen
//   packet is loaded into a one-entry output register; a packet leaving and a
//   new one arriving in the same cycle reload it without a bubble.
//   Ports:
//     clk_tb            in   clock
//     reset_tb          in   asynchronous active-high reset
//     pkt_in_data_in    in   per-channel packet (unpacked array)
//     pkt_in_vld_in     in   per-channel valid
//     pkt_in_rdy_out    out  per-channel ready, at most one bit high
//     pkt_out_data_out  out  merged packet
//     pkt_out_vld_out   out  merged valid
//     pkt_out_rdy_in    in   downstream ready
//     pkt_out_chan_out  out  source channel of the packet on pkt_out_data_out
//     mg_cnt_out        out  number of packets merged, wraps silently
module pkt_merger
  import pkt_merger_pkg::*;
#(
  parameter  int PACKET_BITS  = pkt_merger_pkg::PACKET_BITS,
  parameter  int NUM_CHANNELS = pkt_merger_pkg::NUM_CHANNELS,
  parameter  int CNT_BITS     = 32,
  localparam int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk_tb,
  input  logic                    reset_tb,
  input  logic [PACKET_BITS-1:0]  pkt_in_data_in [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] pkt_in_vld_in,
  output logic [NUM_CHANNELS-1:0] pkt_in_rdy_out,
  output logic [PACKET_BITS-1:0]  pkt_out_data_out,
  output logic                    pkt_out_vld_out,
  input  logic                    pkt_out_rdy_in,
  output logic [CHAN_BITS-1:0]    pkt_out_chan_out,
  output logic [CNT_BITS-1:0]     mg_cnt_out
);

  logic [CHAN_BITS-1:0]    last_grant;
  logic [CHAN_BITS-1:0]    grant_idx;
  logic [NUM_CHANNELS-1:0] grant;
  logic                    out_free;
  logic                    armed;
  logic                    in_hs;

  assign out_free = !pkt_out_vld_out || pkt_out_rdy_in;

  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_arb (
    .req       (pkt_in_vld_in),
    .advance   (out_free && armed),
    .ptr       (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The arbiter only issues a grant for a valid channel, so the one-hot grant
  // is both the ready vector and the handshake indicator.
  assign pkt_in_rdy_out = grant;
  assign in_hs          = |grant;

  // armed holds every ready low during reset and for the first edge after
  // release, so no packet is accepted before the inputs have been sampled.
  always_ff @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Output stage, arbitration pointer and merge counter. A stall blocks the
  // input handshake, so every register simply holds in that case.
  always_ff @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      pkt_out_data_out <= '0;
      pkt_out_chan_out <= '0;
      pkt_out_vld_out  <= 1'b0;
      last_grant       <= CHAN_BITS'(NUM_CHANNELS - 1);
      mg_cnt_out       <= '0;
    end else if (in_hs) begin
      pkt_out_data_out <= pkt_in_data_in[grant_idx];
      pkt_out_chan_out <= grant_idx;
      pkt_out_vld_out  <= 1'b1;
      last_grant       <= grant_idx;
      mg_cnt_out       <= mg_cnt_out + 1'b1;
    end else if (pkt_out_vld_out && pkt_out_rdy_in) begin
      pkt_out_vld_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_merger.sv
// tb_pkt_merger
//   Directed bench for pkt_merger. Two instances share every input: the
//   default one and one with a 4-bit counter for the wrap case. Each source
//   channel c emits packets whose key is 0x10*c + seq, and every packet that
//   leaves the merger is checked against the next expected packet of its
//   channel, so loss, duplication or corruption shows up as a mismatch.
module tb_pkt_merger;
  import pkt_merger_pkg::*;

  localparam int NCH = 8;

  logic           clk_tb = 1'b0;
  logic           reset_tb;
  packet_t        pkt_in_data_in [NCH];
  logic [NCH-1:0] pkt_in_vld_in;
  logic [NCH-1:0] pkt_in_rdy_out;
  logic [NCH-1:0] pkt_in_rdy_out_w;
  packet_t        pkt_out_data_out;
  packet_t        pkt_out_data_out_w;
  logic           pkt_out_vld_out;
  logic           pkt_out_vld_out_w;
  logic           pkt_out_rdy_in;
  logic [2:0]     pkt_out_chan_out;
  logic [2:0]     pkt_out_chan_out_w;
  logic [31:0]    mg_cnt_out;
  logic [3:0]     mg_cnt_out_w;

  int seq_in    [NCH];
  int remaining [NCH];
  int exp_seq   [NCH];
  int n_checks = 0;
  int n_fail   = 0;
  int consumed = 0;
  int cyc;
  packet_t stall_pkt;

  always #5 clk_tb = ~clk_tb;

  pkt_merger #(
    .PACKET_BITS  (PACKET_BITS),
    .NUM_CHANNELS (NCH),
    .CNT_BITS     (32)
  ) dut (
    .clk_tb           (clk_tb),
    .reset_tb         (reset_tb),
    .pkt_in_data_in   (pkt_in_data_in),
    .pkt_in_vld_in    (pkt_in_vld_in),
    .pkt_in_rdy_out   (pkt_in_rdy_out),
    .pkt_out_data_out (pkt_out_data_out),
    .pkt_out_vld_out  (pkt_out_vld_out),
    .pkt_out_rdy_in   (pkt_out_rdy_in),
    .pkt_out_chan_out (pkt_out_chan_out),
    .mg_cnt_out       (mg_cnt_out)
  );

  pkt_merger #(
    .PACKET_BITS  (PACKET_BITS),
    .NUM_CHANNELS (NCH),
    .CNT_BITS     (4)
  ) dut_w (
    .clk_tb           (clk_tb),
    .reset_tb         (reset_tb),
    .pkt_in_data_in   (pkt_in_data_in),
    .pkt_in_vld_in    (pkt_in_vld_in),
    .pkt_in_rdy_out   (pkt_in_rdy_out_w),
    .pkt_out_data_out (pkt_out_data_out_w),
    .pkt_out_vld_out  (pkt_out_vld_out_w),
    .pkt_out_rdy_in   (pkt_out_rdy_in),
    .pkt_out_chan_out (pkt_out_chan_out_w),
    .mg_cnt_out       (mg_cnt_out_w)
  );

  function automatic packet_t make_pkt(input int c, input int s);
    packet_t p;
    p = '0;
    p[PACKET_BITS-1:KEY_LSB+KEY_BITS] = 32'hA500_0000 | 32'(c);
    p[KEY_LSB +: KEY_BITS]            = 32'(16 * c + s);
    p[KEY_LSB-1:0]                    = 8'h5C;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Restart every source at seq 0 with the given packet budget.
  task automatic startSources(input int budget);
    for (int c = 0; c < NCH; c++) begin
      seq_in[c]         = 0;
      exp_seq[c]        = 0;
      remaining[c]      = budget;
      pkt_in_data_in[c] = make_pkt(c, 0);
    end
    pkt_in_vld_in = '1;
  endtask

  // One clock cycle: note the handshakes just before the edge, score any
  // packet leaving the merger, then advance the sources that were accepted.
  task automatic applyStimulus();
    logic [NCH-1:0] hs_in;
    logic           out_hs;
    int             oc;
    packet_t        od;
    #1;
    hs_in  = pkt_in_vld_in & pkt_in_rdy_out;
    out_hs = pkt_out_vld_out && pkt_out_rdy_in;
    oc     = int'(pkt_out_chan_out);
    od     = pkt_out_data_out;
    if (pkt_out_vld_out && !pkt_out_rdy_in)
      checkOutput("stall_rdy", 72'(pkt_in_rdy_out), 72'(0));
    if (out_hs) begin
      checkOutput($sformatf("sb_ch%0d", oc), od, make_pkt(oc, exp_seq[oc]));
      exp_seq[oc]++;
      consumed++;
    end
    @(posedge clk_tb);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (hs_in[c]) begin
        seq_in[c]++;
        remaining[c]--;
        if (remaining[c] == 0) pkt_in_vld_in[c] = 1'b0;
        else pkt_in_data_in[c] = make_pkt(c, seq_in[c]);
      end
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with every channel already requesting.
    reset_tb       = 1'b1;
    pkt_out_rdy_in = 1'b1;
    startSources(6);
    #2;
    checkOutput("reset_rdy",  72'(pkt_in_rdy_out),   72'(0));
    checkOutput("reset_vld",  72'(pkt_out_vld_out),  72'(0));
    checkOutput("reset_data", pkt_out_data_out,      72'(0));
    checkOutput("reset_chan", 72'(pkt_out_chan_out), 72'(0));
    checkOutput("reset_cnt",  72'(mg_cnt_out),       72'(0));
    checkOutput("reset_cntw", 72'(mg_cnt_out_w),     72'(0));
    #10;
    reset_tb = 1'b0;

    // No handshake on the first edge after release; channel 0 goes first.
    applyStimulus();
    checkOutput("first_edge_vld", 72'(pkt_out_vld_out), 72'(0));
    checkOutput("first_rdy",      72'(pkt_in_rdy_out),  72'(8'h01));

    // All channels valid: grants 0..7,0..7,0 with no bubbles.
    $display("[TB] all channels, downstream always ready");
    for (int i = 1; i <= 17; i++) begin
      applyStimulus();
      checkOutput($sformatf("rr_chan_%0d", i), 72'(pkt_out_chan_out), 72'((i - 1) % 8));
      checkOutput($sformatf("rr_data_%0d", i), pkt_out_data_out,
                  make_pkt((i - 1) % 8, (i - 1) / 8));
      checkOutput($sformatf("rr_vld_%0d", i), 72'(pkt_out_vld_out), 72'(1));
      if (i == 15) checkOutput("wrap_cnt_15", 72'(mg_cnt_out_w), 72'(15));
      if (i == 16) begin
        checkOutput("cnt_16",      72'(mg_cnt_out),   72'(16));
        checkOutput("wrap_cnt_16", 72'(mg_cnt_out_w), 72'(0));
      end
      if (i == 17) checkOutput("wrap_cnt_17", 72'(mg_cnt_out_w), 72'(1));
    end

    // Backpressure: the 17th packet (channel 0, seq 2) must sit still.
    $display("[TB] backpressure");
    pkt_out_rdy_in = 1'b0;
    stall_pkt      = make_pkt(0, 2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("stall_chan", 72'(pkt_out_chan_out), 72'(0));
      checkOutput("stall_data", pkt_out_data_out,      stall_pkt);
      checkOutput("stall_cnt",  72'(mg_cnt_out),       72'(17));
    end
    cyc = 0;
    while (!(pkt_in_vld_in == '0 && !pkt_out_vld_out) && cyc < 300) begin
      pkt_out_rdy_in = ~pkt_out_rdy_in;
      applyStimulus();
      cyc++;
    end
    checkOutput("drain_in_time", 72'(cyc < 300),      72'(1));
    checkOutput("drain_consumed", 72'(consumed),      72'(48));
    checkOutput("drain_cnt",      72'(mg_cnt_out),    72'(48));
    checkOutput("idle_rdy",       72'(pkt_in_rdy_out), 72'(0));

    // Sparse: park the pointer on 6, then only 1 and 6 request.
    $display("[TB] sparse requests");
    pkt_out_rdy_in    = 1'b1;
    remaining[6]      = 1;
    pkt_in_data_in[6] = make_pkt(6, seq_in[6]);
    pkt_in_vld_in     = 8'h40;
    #1;
    checkOutput("solo_rdy", 72'(pkt_in_rdy_out), 72'(8'h40));
    applyStimulus();
    checkOutput("solo_chan", 72'(pkt_out_chan_out), 72'(6));
    remaining[1]      = 2;
    remaining[6]      = 2;
    pkt_in_data_in[1] = make_pkt(1, seq_in[1]);
    pkt_in_data_in[6] = make_pkt(6, seq_in[6]);
    pkt_in_vld_in     = 8'h42;
    #1;
    checkOutput("sparse_rdy", 72'(pkt_in_rdy_out), 72'(8'h02));
    applyStimulus();
    checkOutput("sparse_1", 72'(pkt_out_chan_out), 72'(1));
    applyStimulus();
    checkOutput("sparse_2", 72'(pkt_out_chan_out), 72'(6));
    applyStimulus();
    checkOutput("sparse_3", 72'(pkt_out_chan_out), 72'(1));
    applyStimulus();
    checkOutput("sparse_4", 72'(pkt_out_chan_out), 72'(6));
    applyStimulus();
    checkOutput("sparse_cnt",  72'(mg_cnt_out),      72'(53));
    checkOutput("sparse_done", 72'(pkt_out_vld_out), 72'(0));

    // Reset while a packet is held, five packets into a new burst.
    $display("[TB] reset mid-stream");
    startSources(6);
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("pre_reset_cnt", 72'(mg_cnt_out),       72'(58));
    checkOutput("pre_reset_vld", 72'(pkt_out_vld_out),  72'(1));
    checkOutput("pre_reset_ch",  72'(pkt_out_chan_out), 72'(3));
    reset_tb = 1'b1;
    #1;
    checkOutput("mid_reset_vld",  72'(pkt_out_vld_out),  72'(0));
    checkOutput("mid_reset_cnt",  72'(mg_cnt_out),       72'(0));
    checkOutput("mid_reset_chan", 72'(pkt_out_chan_out), 72'(0));
    checkOutput("mid_reset_data", pkt_out_data_out,      72'(0));
    checkOutput("mid_reset_rdy",  72'(pkt_in_rdy_out),   72'(0));
    startSources(6);
    @(posedge clk_tb);
    #3;
    reset_tb = 1'b0;
    applyStimulus();
    checkOutput("rel_vld", 72'(pkt_out_vld_out), 72'(0));
    checkOutput("rel_rdy", 72'(pkt_in_rdy_out),  72'(8'h01));
    applyStimulus();
    checkOutput("rel_chan", 72'(pkt_out_chan_out), 72'(0));
    checkOutput("rel_data", pkt_out_data_out,      make_pkt(0, 0));
    checkOutput("rel_cnt",  72'(mg_cnt_out),       72'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
